// File: rtl/game_over_ctrl_pkg.sv
// Purpose: shared game constants (state encoding, default life count, timer lengths).
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
// Contents:
//   CNT_W              - width of every game timer
//   *_DEF              - default LIVES / GRACE_CYCLES / HOLD_CYCLES
//   game_state_t       - PLAY / GRACE / OVER encoding, shared with blinker and display
//   last_count()       - terminal timer value for an N-cycle interval
package game_over_ctrl_pkg;

  localparam int CNT_W            = 32;
  localparam int LIVES_DEF        = 3;
  localparam int GRACE_CYCLES_DEF = 25000000;
  localparam int HOLD_CYCLES_DEF  = 50000000;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_GRACE = 2'd1,
    ST_OVER  = 2'd2
  } game_state_t;

  // A timer that starts at 0 and runs N cycles ends at N-1. Intervals shorter
  // than one cycle are clamped so the terminal value never wraps to all-ones.
  function automatic logic [CNT_W-1:0] last_count(input int cycles);
    if (cycles < 1) begin
      return '0;
    end
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Purpose: two-flop synchroniser for an asynchronous button level plus rising-edge detect.
// Latency: rise asserts two clk edges after btn goes high and lasts exactly one cycle.
// Backpressure: none; one rise per synchronised low-to-high transition.
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous active-high reset, clears all three flops
//   btn  - raw asynchronous button level
//   rise - one-cycle pulse on a synchronised rising edge
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic sync_q1;
  logic sync_q2;
  logic sync_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_q1   <= btn;
      sync_q2   <= sync_q1;
      sync_prev <= sync_q2;
    end
  end

  // Edge taken only from the synchronised level, never from the raw pin.
  assign rise = sync_q2 & ~sync_prev;

endmodule

// File: rtl/game_over_ctrl.sv
// Purpose: life counter, post-hit invulnerability and game-over/restart sequencing.
// Latency: every output is registered; a hit shows up one cycle later, a restart
//          press three cycles after the raw button rises (two sync flops + edge).
// Backpressure: none; hits in GRACE/OVER and early restart presses are dropped.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   hit          - one-cycle pulse, player struck
//   restart_btn  - raw asynchronous button level
//   over         - high while the game is over (feeds the LED blinker)
//   lives        - remaining lives
//   grace        - high while hits are ignored after a non-fatal hit
//   new_game     - one-cycle pulse when a restart is accepted
module game_over_ctrl
  import game_over_ctrl_pkg::*;
#(
  parameter int LIVES        = LIVES_DEF,
  parameter int GRACE_CYCLES = GRACE_CYCLES_DEF,
  parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       restart_btn,
  output logic       over,
  output logic [1:0] lives,
  output logic       grace,
  output logic       new_game
);

  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
  localparam logic [CNT_W-1:0] GRACE_LAST = last_count(GRACE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST  = last_count(HOLD_CYCLES);

  logic btn_rise;

  btn_edge_sync u_btn_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .btn  (restart_btn),
    .rise (btn_rise)
  );

  game_state_t      state;
  game_state_t      state_nxt;
  // One timer serves both GRACE and OVER; the two states never overlap.
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic [1:0]       lives_nxt;
  logic             over_nxt;
  logic             grace_nxt;
  logic             new_game_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_PLAY;
      timer    <= '0;
      lives    <= LIVES_INIT;
      over     <= 1'b0;
      grace    <= 1'b0;
      new_game <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      lives    <= lives_nxt;
      over     <= over_nxt;
      grace    <= grace_nxt;
      new_game <= new_game_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    lives_nxt    = lives;
    over_nxt     = over;
    grace_nxt    = grace;
    new_game_nxt = 1'b0;

    case (state)
      ST_PLAY: begin
        over_nxt  = 1'b0;
        grace_nxt = 1'b0;
        if (hit) begin
          timer_nxt = '0;
          if (lives > 2'd1) begin
            lives_nxt = lives - 2'd1;
            state_nxt = ST_GRACE;
            grace_nxt = 1'b1;
          end else begin
            // Last life (or an already-empty counter) ends the game; the
            // counter is forced to 0 rather than decremented so it cannot wrap.
            lives_nxt = 2'd0;
            state_nxt = ST_OVER;
            over_nxt  = 1'b1;
          end
        end
      end

      ST_GRACE: begin
        grace_nxt = 1'b1;
        if (timer >= GRACE_LAST) begin
          state_nxt = ST_PLAY;
          timer_nxt = '0;
          grace_nxt = 1'b0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      ST_OVER: begin
        over_nxt = 1'b1;
        // Restart takes priority over any hit in the same cycle; hits are
        // simply not looked at here.
        if (btn_rise && (timer >= HOLD_LAST)) begin
          state_nxt    = ST_PLAY;
          timer_nxt    = '0;
          lives_nxt    = LIVES_INIT;
          over_nxt     = 1'b0;
          new_game_nxt = 1'b1;
        end else if (timer < HOLD_LAST) begin
          timer_nxt = timer + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_PLAY;
        timer_nxt = '0;
        lives_nxt = LIVES_INIT;
        over_nxt  = 1'b0;
        grace_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_game_over_ctrl.sv
module tb_game_over_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hit = 1'b0;
  logic       restart_btn = 1'b0;
  logic       over;
  logic [1:0] lives;
  logic       grace;
  logic       new_game;

  typedef struct packed {
    logic [1:0] lives;
    logic       over;
    logic       grace;
    logic       new_game;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  game_over_ctrl #(
    .LIVES        (3),
    .GRACE_CYCLES (4),
    .HOLD_CYCLES  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hit         (hit),
    .restart_btn (restart_btn),
    .over        (over),
    .lives       (lives),
    .grace       (grace),
    .new_game    (new_game)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [1:0] l, input logic o, input logic g, input logic n);
    exp_t e;
    e.lives = l; e.over = o; e.grace = g; e.new_game = n;
    return e;
  endfunction

  function automatic exp_t observed();
    return mk(lives, over, grace, new_game);
  endfunction

  // Drive one cycle of stimulus, queue what the outputs must be after the edge.
  task automatic run(input logic h, input logic b, input exp_t e);
    hit = h;
    restart_btn = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    hit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hit = 1'b0;
    restart_btn = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Lose all three lives, hits 6 cycles apart; returns 1ns after the fatal edge.
  task automatic idle_to_over();
    for (int i = 0; i < 13; i++) begin
      hit = (i % 6 == 0);
      @(posedge clk);
      #1;
      hit = 1'b0;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    #2;
    sb.push_back(mk(2'd3, 1'b0, 1'b0, 1'b0));
    e = sb.pop_front();
    tests++;
    if (observed() !== e) begin
      fails++;
      $display("FAIL reset_async got=%b want=%b (lives,over,grace,new_game)", observed(), e);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      run(1'b0, 1'b0, mk(2'd3, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      tests++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL reset_idle[%0d] got=%b want=%b", i, observed(), e);
      end
    end
  endtask

  task automatic test_grace();
    exp_t e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      // second hit at cycle 2 lands inside the grace window
      run((i == 0) || (i == 2), 1'b0, mk(2'd2, 1'b0, (i < 4), 1'b0));
      e = sb.pop_front();
      tests++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL grace[%0d] got=%b want=%b", i, observed(), e);
      end
    end
  endtask

  task automatic test_lives_to_over();
    exp_t e;
    logic [1:0] l;
    do_reset();
    // first hit lands on the first edge after reset release
    for (int i = 0; i < 16; i++) begin
      l = (i < 6) ? 2'd2 : (i < 12) ? 2'd1 : 2'd0;
      run((i % 6 == 0) && (i <= 12), 1'b0,
          mk(l, (i >= 12), ((i % 6) < 4) && (i < 12), 1'b0));
      e = sb.pop_front();
      tests++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL lives_to_over[%0d] got=%b want=%b", i, observed(), e);
      end
    end
  endtask

  task automatic test_restart();
    exp_t e;
    do_reset();
    idle_to_over();
    // early press (seen at hold count 3), release, press again after hold expires;
    // a hit coincides with the accepted restart and must lose
    for (int i = 0; i < 14; i++) begin
      run((i == 5) || (i == 10), (i >= 1 && i < 3) || (i >= 8),
          mk((i >= 10) ? 2'd3 : 2'd0, (i < 10), 1'b0, (i == 10)));
      e = sb.pop_front();
      tests++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL restart[%0d] got=%b want=%b", i, observed(), e);
      end
    end
  endtask

  task automatic test_held_button();
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run(1'b0, 1'b1, mk(2'd3, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      tests++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL held_play[%0d] got=%b want=%b", i, observed(), e);
      end
    end
    idle_to_over();
    for (int i = 0; i < 19; i++) begin
      run(1'b0, (i < 12) || (i >= 14),
          mk((i >= 16) ? 2'd3 : 2'd0, (i < 16), 1'b0, (i == 16)));
      e = sb.pop_front();
      tests++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL held_over[%0d] got=%b want=%b", i, observed(), e);
      end
    end
  endtask

  task automatic test_rst_async();
    exp_t e;
    // reset in the middle of GRACE
    do_reset();
    run(1'b1, 1'b0, mk(2'd2, 1'b0, 1'b1, 1'b0));
    e = sb.pop_front();
    tests++;
    if (observed() !== e) begin
      fails++;
      $display("FAIL rst_grace_entry got=%b want=%b", observed(), e);
    end
    #2;
    rst = 1'b1;
    #1;
    sb.push_back(mk(2'd3, 1'b0, 1'b0, 1'b0));
    e = sb.pop_front();
    tests++;
    if (observed() !== e) begin
      fails++;
      $display("FAIL rst_mid_grace got=%b want=%b", observed(), e);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run(1'b0, 1'b0, mk(2'd3, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      tests++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL rst_after_grace[%0d] got=%b want=%b", i, observed(), e);
      end
    end
    // reset in the middle of OVER, after the hold window has run out
    idle_to_over();
    for (int i = 0; i < 10; i++) begin
      run(1'b0, 1'b0, mk(2'd0, 1'b1, 1'b0, 1'b0));
      e = sb.pop_front();
      tests++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL rst_over_hold[%0d] got=%b want=%b", i, observed(), e);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    sb.push_back(mk(2'd3, 1'b0, 1'b0, 1'b0));
    e = sb.pop_front();
    tests++;
    if (observed() !== e) begin
      fails++;
      $display("FAIL rst_mid_over got=%b want=%b", observed(), e);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run(1'b0, 1'b0, mk(2'd3, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      tests++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL rst_after_over[%0d] got=%b want=%b", i, observed(), e);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_grace();
    test_lives_to_over();
    test_restart();
    test_held_button();
    test_rst_async();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d want=0 entries left", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_over_ctrl.md
GAME_OVER_CTRL -- requirements
Module: game_over_ctrl

Interface
REQ-001 SHALL have parameter LIVES, default 3, starting life count (1..3).
REQ-002 SHALL have parameter GRACE_CYCLES, default 25000000, post-hit invulnerability length in clk cycles.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50000000, minimum clk cycles spent in OVER before a restart is accepted.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port hit  input  1  synchronous single-cycle pulse, player struck.
REQ-007 SHALL have port restart_btn  input  1  raw asynchronous push-button level, active-high.
REQ-008 SHALL have port over  output  1  level, high while game is over; drives the LED blinker's over input.
REQ-009 SHALL have port lives  output  2  remaining lives, unsigned.
REQ-010 SHALL have port grace  output  1  high while hits are ignored after a hit.
REQ-011 SHALL have port new_game  output  1  single-cycle pulse when a new game starts.

Function
REQ-012 SHALL implement FSM states PLAY, GRACE, OVER; all outputs registered.
REQ-013 SHALL synchronise restart_btn through two flip-flops, then detect a rising edge (btn_rise) from the synchronised level.
REQ-014 PLAY: hit with lives>1 -> lives decrements by 1 next cycle, state GRACE, grace timer cleared to 0.
REQ-015 PLAY: hit with lives==1 -> lives becomes 0, state OVER, hold timer cleared to 0, over high next cycle.
REQ-016 GRACE: grace high; timer increments each cycle; hit ignored; at timer==GRACE_CYCLES-1 -> PLAY next cycle, grace low.
REQ-017 OVER: over high; hold timer increments and saturates at HOLD_CYCLES-1; btn_rise ignored until saturation.
REQ-018 OVER: btn_rise with hold timer saturated -> lives reloads LIVES, state PLAY, over low, new_game high for exactly one cycle.
REQ-019 btn_rise in PLAY or GRACE SHALL be ignored; a button held through OVER entry SHALL NOT restart without a fresh rising edge.
REQ-020 hit and btn_rise in the same cycle in OVER: restart wins; hit ignored.
REQ-021 Counters SHALL be 32 bits wide; no wrap-around reachable (saturate/clear as above).
REQ-022 lives SHALL never underflow below 0 nor exceed LIVES.

Reset
REQ-023 rst high SHALL immediately force: state PLAY, lives=LIVES, over=0, grace=0, new_game=0, timers=0, synchroniser and edge registers=0.
REQ-024 rst asserted mid-GRACE or mid-OVER SHALL abandon that state with no new_game pulse on release.
REQ-025 First rising clk after rst release SHALL evaluate hit normally.

Structure
REQ-026 State encodings and default LIVES/GRACE_CYCLES/HOLD_CYCLES SHALL live in a shared game constants package used by the blinker and display blocks.
REQ-027 The synchroniser plus edge detector SHALL be a sub-module btn_edge_sync (ports clk, rst, btn, rise), reusable for other buttons.
REQ-028 Simulation SHALL override GRACE_CYCLES=4, HOLD_CYCLES=8.

Verification (GRACE_CYCLES=4, HOLD_CYCLES=8, LIVES=3)
REQ-029 Reset then idle 20 cycles -> lives=3, over=0, grace=0, new_game never pulses.
REQ-030 One hit -> lives=2 and grace=1 next cycle; second hit 2 cycles later ignored; grace falls after 4 cycles, lives stays 2.
REQ-031 Three hits spaced 6 cycles -> lives 2,1,0; over=1 the cycle after third hit; grace not asserted on the fatal hit.
REQ-032 In OVER, button press at hold count 3 -> ignored; release and press after 8 cycles -> lives=3, over=0, new_game one-cycle pulse.
REQ-033 Button held high across OVER entry and beyond 8 cycles -> no restart until released and re-pressed.
REQ-034 rst pulsed during GRACE and during OVER -> outputs return to reset values asynchronously, no new_game pulse.
